// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// Module  : fetch_pc_unit
// Purpose : Program-counter owner on the fetch side. Issues sequential imem
//           requests, buffers returned words for decode and handles redirects.
// Option  : FETCH_ADEL_CHECK_EN enables misaligned-redirect address errors.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_adel
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      pend_pc;
  logic             drop;
  logic [31:0]      pc_buf   [BUF_DEPTH];
  logic [31:0]      inst_buf [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             halt;
  logic             adel_push;
  logic [31:0]      redirect_tgt;
  logic             issue;
  logic             push_data;
  logic             push;
  logic             pop;
  logic [31:0]      push_pc;
  logic [31:0]      push_inst;

`ifdef FETCH_ADEL_CHECK_EN
  logic adel_buf [BUF_DEPTH];
  logic adel_pend;
  logic halt_q;
  logic redirect_mis;

  assign redirect_mis = (redirect_pc[1:0] != 2'b00);
  assign halt         = halt_q;
  assign adel_push    = adel_pend && !redirect_valid && (count < DEPTH_CNT);
  assign redirect_tgt = redirect_pc;

  // A misaligned target becomes a single error entry, then fetch idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      adel_pend <= 1'b0;
      halt_q    <= 1'b0;
    end else if (redirect_valid) begin
      adel_pend <= redirect_mis;
      halt_q    <= redirect_mis;
    end else if (adel_push) begin
      adel_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) adel_buf[wr_ptr] <= adel_push;
  end

  assign inst_adel = inst_valid && adel_buf[rd_ptr];
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halt                 = 1'b0;
  assign adel_push            = 1'b0;
  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign inst_adel            = 1'b0;
`endif

  assign imem_req  = (state == S_REQ) && (count < DEPTH_CNT) && !halt;
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  assign push_data = (state == S_WAIT) && imem_rvalid && !drop && !redirect_valid;
  assign push      = push_data || adel_push;
  assign pop       = inst_valid && dec_ready && !redirect_valid;
  assign push_pc   = adel_push ? fetch_pc : pend_pc;
  assign push_inst = adel_push ? 32'h0000_0000 : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Redirect never changes the handshake state: an in-flight word is drained.
  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   if (issue)       state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= 32'h0000_0000;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) pend_pc <= fetch_pc;

      if (redirect_valid) fetch_pc <= redirect_tgt;
      else if (issue)     fetch_pc <= fetch_pc + 32'd4;

      if (redirect_valid) begin
        drop <= (state == S_WAIT) ? !imem_rvalid : issue;
      end else if ((state == S_WAIT) && imem_rvalid) begin
        drop <= 1'b0;
      end

      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]   <= push_pc;
      inst_buf[wr_ptr] <= push_inst;
    end
  end

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? inst_buf[rd_ptr] : 32'h0000_0000;
  assign inst_pc    = inst_valid ? pc_buf[rd_ptr]   : 32'h0000_0000;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// Module  : tb_fetch_pc_unit
// Purpose : Directed self-checking bench for fetch_pc_unit (default build).
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_adel;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I0   = 32'h2408_0001;
  localparam logic [31:0] I1   = 32'h2409_0002;
  localparam logic [31:0] I2   = 32'h012A_5820;
  localparam logic [31:0] I3   = 32'h3C01_8000;
  localparam logic [31:0] I4   = 32'h0800_0040;
  localparam logic [31:0] I5   = 32'hAC22_0004;
  localparam logic [31:0] I6   = 32'h8C23_0008;
  localparam logic [31:0] I7   = 32'h1000_FFFF;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  fetch_pc_unit #(
    .RESET_PC  (32'hBFC0_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_adel      (inst_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic redir, input logic [31:0] rpc);
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values and sequential fetch with decode always ready
    reset_dut();
    chk("rst_req",   {31'h0, imem_req},   32'h1);
    chk("rst_addr",  imem_addr,           32'hBFC0_0000);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc",    inst_pc,             32'h0);
    chk("rst_adel",  {31'h0, inst_adel},  32'h0);

    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("seq_wait_req", {31'h0, imem_req}, 32'h0);
    chk("seq_addr1",    imem_addr,         32'hBFC0_0004);
    cyc(1'b0, 1'b1, I0, 1'b1, 1'b0, 32'h0);
    chk("seq_valid0", {31'h0, inst_valid}, 32'h1);
    chk("seq_pc0",    inst_pc,             32'hBFC0_0000);
    chk("seq_inst0",  inst,                I0);
    chk("seq_req1",   {31'h0, imem_req},   32'h1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("seq_popped", {31'h0, inst_valid}, 32'h0);
    cyc(1'b0, 1'b1, I1, 1'b1, 1'b0, 32'h0);
    chk("seq_pc1",   inst_pc,   32'hBFC0_0004);
    chk("seq_addr2", imem_addr, 32'hBFC0_0008);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I2, 1'b1, 1'b0, 32'h0);
    chk("seq_pc2",   inst_pc, 32'hBFC0_0008);
    chk("seq_inst2", inst,    I2);

    // Back-pressure: buffer fills after two fetches
    reset_dut();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I1, 1'b0, 1'b0, 32'h0);
    chk("full_req",  {31'h0, imem_req}, 32'h0);
    chk("full_head", inst_pc,           32'hBFC0_0000);
    chk("full_addr", imem_addr,         32'hBFC0_0008);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("full_gnt_ignored", imem_addr, 32'hBFC0_0008);
    chk("full_head_hold",   inst_pc,   32'hBFC0_0000);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("pop1_head", inst_pc,           32'hBFC0_0004);
    chk("pop1_req",  {31'h0, imem_req}, 32'h1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("one_issue_req",  {31'h0, imem_req}, 32'h0);
    chk("one_issue_addr", imem_addr,         32'hBFC0_000C);
    cyc(1'b0, 1'b1, I2, 1'b0, 1'b0, 32'h0);
    chk("refull_req",  {31'h0, imem_req}, 32'h0);
    chk("refull_head", inst_pc,           32'hBFC0_0004);

    // Redirect while waiting for BFC00004 with one word buffered
    reset_dut();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
    chk("rdw_flush", {31'h0, inst_valid}, 32'h0);
    chk("rdw_req",   {31'h0, imem_req},   32'h0);
    chk("rdw_addr",  imem_addr,           32'h8000_0100);
    cyc(1'b0, 1'b1, JUNK, 1'b0, 1'b0, 32'h0);
    chk("rdw_drop",  {31'h0, inst_valid}, 32'h0);
    chk("rdw_req2",  {31'h0, imem_req},   32'h1);
    chk("rdw_addr2", imem_addr,           32'h8000_0100);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I3, 1'b1, 1'b0, 32'h0);
    chk("rdw_pc",   inst_pc, 32'h8000_0100);
    chk("rdw_inst", inst,    I3);

    // Redirect in the same cycle as the grant for BFC00008
    reset_dut();
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I1, 1'b1, 1'b0, 32'h0);
    chk("rg_pre_addr", imem_addr, 32'hBFC0_0008);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h9000_0000);
    chk("rg_flush", {31'h0, inst_valid}, 32'h0);
    chk("rg_req",   {31'h0, imem_req},   32'h0);
    cyc(1'b0, 1'b1, JUNK, 1'b1, 1'b0, 32'h0);
    chk("rg_drop", {31'h0, inst_valid}, 32'h0);
    chk("rg_addr", imem_addr,           32'h9000_0000);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I4, 1'b1, 1'b0, 32'h0);
    chk("rg_pc",   inst_pc, 32'h9000_0000);
    chk("rg_inst", inst,    I4);

    // Redirect from idle S_REQ to FFFFFFFC: latency and address wrap
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_req_t1",  {31'h0, imem_req},   32'h1);
    chk("wrap_addr0",   imem_addr,           32'hFFFF_FFFC);
    chk("wrap_flush",   {31'h0, inst_valid}, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr1",   imem_addr,           32'h0000_0000);
    cyc(1'b0, 1'b1, I5, 1'b1, 1'b0, 32'h0);
    chk("wrap_valid_t3", {31'h0, inst_valid}, 32'h1);
    chk("wrap_pc0",      inst_pc,             32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I6, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc1",   inst_pc, 32'h0000_0000);
    chk("wrap_inst1", inst,    I6);

    // Redirect coinciding with rvalid; unaligned target is word-aligned
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, JUNK, 1'b1, 1'b1, 32'h8000_0102);
    chk("rrv_drop", {31'h0, inst_valid}, 32'h0);
    chk("rrv_req",  {31'h0, imem_req},   32'h1);
    chk("rrv_addr", imem_addr,           32'h8000_0100);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I7, 1'b1, 1'b0, 32'h0);
    chk("rrv_pc",   inst_pc,            32'h8000_0100);
    chk("rrv_inst", inst,               I7);
    chk("rrv_adel", {31'h0, inst_adel}, 32'h0);

    // Reset with a pending drop clears it
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000);
    reset_dut();
    chk("mrst_req",   {31'h0, imem_req},   32'h1);
    chk("mrst_addr",  imem_addr,           32'hBFC0_0000);
    chk("mrst_valid", {31'h0, inst_valid}, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, I0, 1'b0, 1'b0, 32'h0);
    chk("mrst_nodrop", {31'h0, inst_valid}, 32'h1);
    chk("mrst_pc",     inst_pc,             32'hBFC0_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
